fir_operand_sequencer: RTL and testbench
========================================

Name: fir_operand_sequencer

Overview:
Producer side of the FIR MAC datapath. It accepts input samples over a valid/ready stream and keeps the last NTAP samples in a circular buffer. It holds NTAP coefficients and feeds one (X, tap) pair per cycle to the free-running FIR MAC kernel, aligned to the kernel's Done frame. It captures the kernel's Y at frame end and returns it on a valid/ready output stream.

Parameters:
NTAP, 11, taps per output; must equal the kernel frame length.
DW, 32, sample, coefficient and result width.
AW, 4, coefficient/buffer index width; 2^AW >= NTAP.

Ports:
CLK  in  1  clock
Resetn  in  1  asynchronous reset, active-low
s_valid  in  1  input sample valid
s_ready  out  1  sequencer can accept a sample
s_data  in  DW  input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  AW  coefficient index, 0..NTAP-1
coef_wdata  in  DW  coefficient value
k_X  out  DW  kernel sample operand
k_tap  out  DW  kernel coefficient operand
k_Y  in  DW  kernel accumulated result
k_done  in  1  kernel frame boundary (Done)
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  DW  filtered output y[n]
busy  out  1  state != IDLE

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE; idx=0; wp=0; all sample-buffer and coefficient entries cleared to 0; m_valid=0; m_data=0. Consequences: s_ready=1, k_X=k_tap=0, busy=0.
- Reset mid-operation discards any in-flight frame and any pending result. The kernel shares Resetn, so the two stay phase-aligned.
- Coefficient write: when coef_we=1, state=IDLE and coef_addr<NTAP, write coef[coef_addr]. Otherwise the write is ignored (busy or out of range).
- s_ready = (state==IDLE) && !m_valid. Single-entry output slot; no new sample is accepted while a result is pending.
- k_X/k_tap are combinational from state and idx, so the kernel samples them on the same edge.
  - In ISSUE, and in WAIT when k_done=1: k_X = buf[(nidx - idx) mod NTAP], k_tap = coef[idx].
  - All other cycles: k_X = k_tap = 0.
- nidx is the buffer slot of the newest sample. Products are therefore tap[i]*x[n-i], i=0..NTAP-1.
- States:
  - IDLE: on s_valid && s_ready, write buf[wp]=s_data, nidx<=wp, wp<=(wp+1) mod NTAP (wraps NTAP-1 -> 0), go to WAIT.
  - WAIT: drive zeros until k_done=1. In that cycle present pair idx=0, set idx<=1, go to ISSUE. Wait lasts 0..NTAP-1 cycles.
  - ISSUE: present pair idx, idx<=idx+1. After presenting idx=NTAP-1, set idx<=0 and go to COLLECT.
  - COLLECT: drive zeros. When k_done=1: m_data<=k_Y, m_valid<=1, go to IDLE. If k_done=0 (misalignment), stay in COLLECT.
- Output handshake: m_valid stays high and m_data stays stable until the cycle with m_valid && m_ready. m_valid clears on that edge.
- Latency: m_valid rises NTAP+1 cycles after the WAIT cycle in which k_done was seen. Total from sample accept is NTAP+2 to 2*NTAP+1 cycles.
- Arithmetic belongs to the kernel: product and accumulation are truncated mod 2^DW, unsigned. The sequencer passes k_Y through unchanged.
- Kernel frames with no pending sample accumulate zeros; their results are discarded.

Decomposition:
- Package fir_pkg: NTAP, DW, AW, and the state encoding (IDLE, WAIT, ISSUE, COLLECT).
- One sub-module, fir_sample_ring:
  - NTAP x DW circular buffer with write pointer and wrap.
  - Asynchronous clear on reset.
  - Combinational read port indexed by (nidx - idx) mod NTAP.

Test Plan:
(All scenarios instantiate the sequencer together with the FIR MAC kernel.)
1. Impulse: coef[i]=i+1, samples 1,0,0,... (13 samples) -> m_data 1,2,3,...,11,0,0.
2. Step: all coef=1, 13 samples of value 2 -> m_data 2,4,...,22,22,22, exercising buffer wrap at wp 10 -> 0.
3. Backpressure: m_ready=0 for 50 cycles after the first result -> m_valid held, m_data stable, s_ready=0, and the next sample is accepted only after the handshake.
4. Coefficient write during busy: coef_we to index 0 with value 99 while in ISSUE -> ignored; outputs match the old coefficients. A write in IDLE takes effect on the next sample.
5. Random: 40 random 16-bit samples and coefficients, m_ready toggled randomly -> every m_data equals the golden model sum(coef[i]*x[n-i]) mod 2^32, in order, with none lost.
6. Reset mid-ISSUE (idx=5): pulse Resetn low -> m_valid=0, busy=0, s_ready=1, coefficients and buffer cleared. A following impulse with coef=0 produces 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared sizing and state encoding for the FIR operand sequencer.
package fir_pkg;

  localparam int NTAP = 11;
  localparam int DW   = 32;
  localparam int AW   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ISSUE   = 2'd2,
    COLLECT = 2'd3
  } state_t;

endpackage

// File: rtl/fir_sample_ring.sv
// Circular history of the last NTAP input samples with a tap-relative read port.
module fir_sample_ring #(
  parameter int NTAP = fir_pkg::NTAP,
  parameter int DW   = fir_pkg::DW,
  parameter int AW   = fir_pkg::AW
) (
  input  logic          CLK,
  input  logic          Resetn,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] idx,
  output logic [DW-1:0] rdata
);

  localparam logic [AW-1:0] NTAP_A = AW'(NTAP);
  localparam logic [AW:0]   NTAP_E = (AW+1)'(NTAP);
  localparam logic [AW-1:0] LAST   = AW'(NTAP - 1);

  logic [DW-1:0] ring_reg [NTAP];
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] nidx_reg;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      wp_reg   <= '0;
      nidx_reg <= '0;
      for (int i = 0; i < NTAP; i++) ring_reg[i] <= '0;
    end else if (we) begin
      ring_reg[wp_reg] <= wdata;
      nidx_reg         <= wp_reg;
      wp_reg           <= (wp_reg == LAST) ? '0 : wp_reg + 1'b1;
    end
  end

  // Tap i reads x[n-i]; stepping back past slot 0 wraps to the top of the ring.
  assign rd_ptr = (nidx_reg >= idx) ? (nidx_reg - idx) : (nidx_reg + NTAP_A - idx);
  assign rdata  = ({1'b0, rd_ptr} < NTAP_E) ? ring_reg[rd_ptr] : '0;

endmodule

// File: rtl/fir_operand_sequencer.sv
// Feeds (sample, coefficient) pairs to the free-running FIR MAC kernel in step
// with its frame boundary and returns each completed sum on an output stream.
module fir_operand_sequencer #(
  parameter int NTAP = fir_pkg::NTAP,
  parameter int DW   = fir_pkg::DW,
  parameter int AW   = fir_pkg::AW
) (
  input  logic          CLK,
  input  logic          Resetn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_wdata,
  output logic [DW-1:0] k_X,
  output logic [DW-1:0] k_tap,
  input  logic [DW-1:0] k_Y,
  input  logic          k_done,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy
);

  import fir_pkg::*;

  localparam logic [AW:0]   NTAP_E = (AW+1)'(NTAP);
  localparam logic [AW-1:0] LAST   = AW'(NTAP - 1);

  state_t        state_reg;
  logic [AW-1:0] idx_reg;
  logic          m_valid_reg;
  logic [DW-1:0] m_data_reg;
  logic [DW-1:0] coef_reg [NTAP];

  logic          s_fire;
  logic          coef_fire;
  logic          present;
  logic [DW-1:0] ring_rdata;

  assign s_ready   = (state_reg == IDLE) && !m_valid_reg;
  assign s_fire    = s_valid && s_ready;
  assign coef_fire = coef_we && (state_reg == IDLE) && ({1'b0, coef_addr} < NTAP_E);

  // The first pair must land on the same edge the kernel restarts its sum.
  assign present = (state_reg == ISSUE) || ((state_reg == WAIT) && k_done);
  assign k_X     = present ? ring_rdata : '0;
  assign k_tap   = present ? coef_reg[idx_reg] : '0;

  assign busy    = (state_reg != IDLE);
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NTAP; i++) coef_reg[i] <= '0;
    end else if (coef_fire) begin
      coef_reg[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      if (m_valid_reg && m_ready) m_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (s_fire) state_reg <= WAIT;
        end
        WAIT: begin
          if (k_done) begin
            idx_reg   <= AW'(1);
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx_reg == LAST) begin
            idx_reg   <= '0;
            state_reg <= COLLECT;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        COLLECT: begin
          // Without k_done here the kernel is out of phase; hold until it ends a frame.
          if (k_done) begin
            m_data_reg  <= k_Y;
            m_valid_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  fir_sample_ring #(
    .NTAP(NTAP),
    .DW  (DW),
    .AW  (AW)
  ) u_ring (
    .CLK   (CLK),
    .Resetn(Resetn),
    .we    (s_fire),
    .wdata (s_data),
    .idx   (idx_reg),
    .rdata (ring_rdata)
  );

endmodule

// File: tb/tb_fir_operand_sequencer.sv
// Sequencer plus a behavioural MAC kernel, checked against a convolution model.
module tb_fir_operand_sequencer;

  import fir_pkg::*;

  logic          CLK = 1'b0;
  logic          Resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [DW-1:0] coef_wdata = '0;
  logic [DW-1:0] k_X;
  logic [DW-1:0] k_tap;
  logic [DW-1:0] k_Y;
  logic          k_done;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy;

  always #5 CLK = ~CLK;

  fir_operand_sequencer dut (
    .CLK(CLK), .Resetn(Resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .k_X(k_X), .k_tap(k_tap), .k_Y(k_Y), .k_done(k_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  // Free-running kernel: frame restarts on the Done edge, Y holds the last full sum.
  int            kcnt;
  logic [DW-1:0] kacc;
  assign k_done = (kcnt == 0);
  assign k_Y    = kacc;
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      kcnt <= 0;
      kacc <= '0;
    end else begin
      kcnt <= (kcnt == NTAP - 1) ? 0 : kcnt + 1;
      kacc <= k_done ? (k_X * k_tap) : (kacc + k_X * k_tap);
    end
  end

  logic [DW-1:0] coef_m [NTAP];
  logic [DW-1:0] hist [$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] x_at(input int i);
    if (i < hist.size()) return hist[hist.size() - 1 - i];
    return '0;
  endfunction

  function automatic logic [DW-1:0] golden();
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < NTAP; i++) acc = acc + coef_m[i] * x_at(i);
    return acc;
  endfunction

  task automatic write_coef(input int addr, input logic [DW-1:0] val, input bit expect_taken);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = val;
    @(negedge CLK);
    coef_we = 1'b0;
    if (expect_taken && addr < NTAP) coef_m[addr] = val;
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("s_accept_timeout", (n < 200) ? 32'd0 : 32'd1, 32'd0);
    @(negedge CLK);
    s_valid = 1'b0;
    hist.push_back(d);
  endtask

  // n0 = negedges already elapsed since the accepting edge.
  task automatic recv(input string tag, input bit rand_ready, input int n0);
    logic [DW-1:0] exp;
    int n;
    bit seen, done;
    exp = golden();
    seen = 0;
    done = 0;
    n = n0;
    while (!done && n < 100) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid) begin
        if (!seen) begin
          check({tag, "_latency"}, (n >= NTAP + 1 && n <= 2 * NTAP) ? 32'd1 : 32'd0, 32'd1);
          seen = 1;
        end
        check(tag, m_data, exp);
        if (m_ready) done = 1;
      end
      @(negedge CLK);
      n++;
    end
    m_ready = 1'b0;
    check({tag, "_timeout"}, done ? 32'd0 : 32'd1, 32'd0);
    if (done) check({tag, "_vclear"}, {31'b0, m_valid}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] exp;
    int n;
    for (int i = 0; i < NTAP; i++) coef_m[i] = '0;

    repeat (3) @(negedge CLK);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_k_X", k_X, 32'd0);
    check("rst_k_tap", k_tap, 32'd0);
    Resetn = 1'b1;
    @(negedge CLK);

    // Impulse response reproduces the coefficients, then zeros.
    for (int i = 0; i < NTAP; i++) write_coef(i, 32'(i + 1), 1);
    for (int i = 0; i < 13; i++) begin
      send_sample((i == 0) ? 32'd1 : 32'd0);
      recv($sformatf("impulse%0d", i), 0, 0);
    end

    // Step input ramps up and saturates across a ring wrap.
    for (int i = 0; i < NTAP; i++) write_coef(i, 32'd1, 1);
    for (int i = 0; i < 13; i++) begin
      send_sample(32'd2);
      recv($sformatf("step%0d", i), 0, 0);
    end

    // Held result blocks further input until the handshake.
    send_sample(32'd5);
    exp = golden();
    n = 0;
    m_ready = 1'b0;
    while (!m_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("bp_wait", {31'b0, m_valid}, 32'd1);
    s_data  = 32'd7;
    s_valid = 1'b1;
    repeat (50) begin
      check("bp_valid", {31'b0, m_valid}, 32'd1);
      check("bp_data", m_data, exp);
      check("bp_s_ready", {31'b0, s_ready}, 32'd0);
      @(negedge CLK);
    end
    m_ready = 1'b1;
    @(negedge CLK);
    m_ready = 1'b0;
    check("bp_vclear", {31'b0, m_valid}, 32'd0);
    check("bp_s_ready_after", {31'b0, s_ready}, 32'd1);
    hist.push_back(32'd7);
    @(negedge CLK);
    s_valid = 1'b0;
    check("bp_accept_busy", {31'b0, busy}, 32'd1);
    recv("bp_next", 0, 0);

    // Coefficient writes are ignored while busy and out of range.
    send_sample(32'd3);
    repeat (3) @(negedge CLK);
    write_coef(0, 32'd99, 0);
    recv("cw_busy", 0, 4);
    write_coef(0, 32'd99, 1);
    write_coef(12, 32'd55, 1);
    send_sample(32'd4);
    recv("cw_idle", 0, 0);

    // Random samples and coefficients with random output backpressure.
    for (int i = 0; i < NTAP; i++) write_coef(i, 32'($urandom_range(0, 65535)), 1);
    for (int i = 0; i < 40; i++) begin
      send_sample(32'($urandom_range(0, 65535)));
      recv($sformatf("rand%0d", i), 1, 0);
    end

    // Asynchronous reset in the middle of an issue frame.
    send_sample(32'd9);
    n = 0;
    while (!k_done && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("rst_phase", {31'b0, k_done}, 32'd1);
    check("issue0_k_tap", k_tap, coef_m[0]);
    check("issue0_k_X", k_X, x_at(0));
    repeat (5) @(negedge CLK);
    check("issue5_k_tap", k_tap, coef_m[5]);
    check("issue5_k_X", k_X, x_at(5));
    check("issue5_busy", {31'b0, busy}, 32'd1);
    Resetn = 1'b0;
    #1;
    check("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("mid_rst_k_X", k_X, 32'd0);
    check("mid_rst_k_tap", k_tap, 32'd0);
    check("mid_rst_m_data", m_data, 32'd0);
    @(negedge CLK);
    Resetn = 1'b1;
    for (int i = 0; i < NTAP; i++) coef_m[i] = '0;
    hist.delete();
    @(negedge CLK);
    send_sample(32'd1);
    recv("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
